// File: rtl/hockey_pkg.sv
// hockey_pkg: shared definitions for the air-hockey match controller.
//   - state_t   : FSM state codes (PAUSE only when HOCKEY_PAUSE_EN is defined)
//   - KEY_*     : PS/2 set-2 make codes the controller reacts to
//   - key_mode  : mode-key decoder, returns {valid, mode index}
//   - mode_step : goal step per tick for a given mode
// Build option: HOCKEY_PAUSE_EN adds the PAUSE state and its key code.
package hockey_pkg;

  typedef enum logic [2:0] {
    ST_MENU   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_SCORED = 3'd2,
    ST_OVER   = 3'd3
`ifdef HOCKEY_PAUSE_EN
    , ST_PAUSE = 3'd4
`endif
  } state_t;

  localparam logic [7:0] KEY_START_A = 8'h29;  // space
  localparam logic [7:0] KEY_START_B = 8'h5A;  // enter
  localparam logic [7:0] KEY_MENU    = 8'h66;  // backspace
  localparam logic [7:0] KEY_QUIT    = 8'h76;  // escape
`ifdef HOCKEY_PAUSE_EN
  localparam logic [7:0] KEY_PAUSE   = 8'h4D;  // P
`endif

  // Digit row 1..8 selects modes 0..7.
  function automatic logic [3:0] key_mode(input logic [7:0] code);
    case (code)
      8'h16:   return 4'b1_000;
      8'h1E:   return 4'b1_001;
      8'h26:   return 4'b1_010;
      8'h25:   return 4'b1_011;
      8'h2E:   return 4'b1_100;
      8'h36:   return 4'b1_101;
      8'h3D:   return 4'b1_110;
      8'h3E:   return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

  // Modes 0-3 keep goals static, 4-5 move slowly, 6-7 move fast.
  function automatic int mode_step(input logic [2:0] m, input int slow, input int fast);
    if (m >= 3'd6)      return fast;
    else if (m >= 3'd4) return slow;
    else                return 0;
  endfunction

endpackage

// File: rtl/goal_mover.sv
// goal_mover: one goal's top-row position with a bouncing direction.
// On step_en the position moves by `step` in the current direction; a move
// that would leave [0, Y_MAX] clamps to that bound and reverses direction.
// restart (or reset) reloads Y0 and the initial direction.
// Ports: clk, reset (sync, high), restart, step_en, step[Y_W], pos[Y_W] out.
module goal_mover #(
  parameter int Y_W     = 9,
  parameter int Y_MAX   = 320,
  parameter int Y0      = 160,
  parameter bit INIT_UP = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           restart,
  input  logic           step_en,
  input  logic [Y_W-1:0] step,
  output logic [Y_W-1:0] pos
);

  localparam logic [Y_W:0] MAX_EXT = (Y_W+1)'(Y_MAX);

  logic         up_q;
  logic [Y_W:0] sum;

  // one extra bit so the downward overflow check cannot wrap
  assign sum = {1'b0, pos} + {1'b0, step};

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      pos  <= Y_W'(Y0);
      up_q <= INIT_UP;
    end else if (step_en) begin
      if (up_q) begin
        if (pos < step) begin
          pos  <= '0;
          up_q <= 1'b0;
        end else begin
          pos <= pos - step;
        end
      end else if (sum > MAX_EXT) begin
        pos  <= Y_W'(Y_MAX);
        up_q <= 1'b1;
      end else begin
        pos <= sum[Y_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hockey_game_ctrl.sv
// hockey_game_ctrl: air-hockey match controller.
// Owns the MENU/PLAY/SCORED/OVER(/PAUSE) FSM, mode selection, scores, the
// serve delay and two moving goals. All outputs are registered.
// Inputs : clk, reset (sync, high), tick, key_stb/key_code/key_rel, goal_l, goal_r
// Outputs: state, mode, score_l/r, goal_y_l/r, play_en, serve, win_l/r
// Build option: HOCKEY_PAUSE_EN enables the PAUSE state (key 0x4D).
module hockey_game_ctrl
  import hockey_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 3,
  parameter int NUM_MODES   = 8,
  parameter int Y_W         = 9,
  parameter int SCREEN_H    = 480,
  parameter int GOAL_H      = 160,
  parameter int GOAL_Y0     = 160,
  parameter int STEP_SLOW   = 2,
  parameter int STEP_FAST   = 5,
  parameter int SERVE_TICKS = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               key_stb,
  input  logic [7:0]         key_code,
  input  logic               key_rel,
  input  logic               goal_l,
  input  logic               goal_r,
  output logic [2:0]         state,
  output logic [2:0]         mode,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [Y_W-1:0]     goal_y_l,
  output logic [Y_W-1:0]     goal_y_r,
  output logic               play_en,
  output logic               serve,
  output logic               win_l,
  output logic               win_r
);

  localparam int                 CNT_W = $clog2(SERVE_TICKS + 1);
  localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);

  state_t               state_q, state_d;
  logic [2:0]           mode_d, mode_idx;
  logic [SCORE_W-1:0]   score_l_d, score_r_d;
  logic                 win_l_d, win_r_d, play_en_d, serve_d;
  logic                 restart, make, mode_ok;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0][Y_W-1:0]  goal_y;
  logic [Y_W-1:0]       step;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN) ? WIN : s + SCORE_W'(1);
  endfunction

  assign make              = key_stb & ~key_rel;
  assign {mode_ok, mode_idx} = key_mode(key_code);
  assign state             = state_q;
  assign step              = Y_W'(mode_step(mode, STEP_SLOW, STEP_FAST));

  // ---- state register (also holds all registered outputs) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_MENU;
      mode    <= '0;
      score_l <= '0;
      score_r <= '0;
      win_l   <= 1'b0;
      win_r   <= 1'b0;
      play_en <= 1'b0;
      serve   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode    <= mode_d;
      score_l <= score_l_d;
      score_r <= score_r_d;
      win_l   <= win_l_d;
      win_r   <= win_r_d;
      play_en <= play_en_d;
      serve   <= serve_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- next state ----
  // Any make code in PLAY takes priority over a goal pulse in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MENU:
        if (make && (key_code == KEY_START_A || key_code == KEY_START_B))
          state_d = ST_PLAY;
      ST_PLAY:
        if (make) begin
          if (key_code == KEY_MENU)      state_d = ST_MENU;
          else if (key_code == KEY_QUIT) state_d = ST_OVER;
`ifdef HOCKEY_PAUSE_EN
          else if (key_code == KEY_PAUSE) state_d = ST_PAUSE;
`endif
        end else if (goal_l) begin
          state_d = (sat_inc(score_r) == WIN) ? ST_OVER : ST_SCORED;
        end else if (goal_r) begin
          state_d = (sat_inc(score_l) == WIN) ? ST_OVER : ST_SCORED;
        end
      ST_SCORED:
        if (make && key_code == KEY_MENU)                 state_d = ST_MENU;
        else if (tick && cnt_q == CNT_W'(SERVE_TICKS - 1)) state_d = ST_PLAY;
      ST_OVER:
        if (make && key_code == KEY_MENU) state_d = ST_MENU;
`ifdef HOCKEY_PAUSE_EN
      ST_PAUSE:
        if (make && key_code == KEY_MENU)       state_d = ST_MENU;
        else if (make && key_code == KEY_PAUSE) state_d = ST_PLAY;
`endif
      default: state_d = ST_MENU;
    endcase
  end

  // ---- outputs (next values of the registered outputs) ----
  always_comb begin
    mode_d    = mode;
    score_l_d = score_l;
    score_r_d = score_r;
    win_l_d   = win_l;
    win_r_d   = win_r;
    cnt_d     = cnt_q;
    restart   = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (make && mode_ok && 32'(mode_idx) < NUM_MODES) mode_d = mode_idx;
        if (state_d == ST_PLAY) begin
          restart   = 1'b1;
          score_l_d = '0;
          score_r_d = '0;
          win_l_d   = 1'b0;
          win_r_d   = 1'b0;
        end
      end
      ST_PLAY: begin
        cnt_d = '0;  // SCORED always starts its delay from zero
        if (!make) begin
          if (goal_l) begin
            score_r_d = sat_inc(score_r);
            win_r_d   = (score_r_d == WIN);
          end else if (goal_r) begin
            score_l_d = sat_inc(score_l);
            win_l_d   = (score_l_d == WIN);
          end
        end
      end
      ST_SCORED:
        if (tick) cnt_d = (state_d == ST_PLAY) ? '0 : cnt_q + CNT_W'(1);
      default: ;
    endcase
    play_en_d = (state_d == ST_PLAY);
    // un-pausing resumes without a fresh serve
    serve_d   = play_en_d && (state_q == ST_MENU || state_q == ST_SCORED);
  end

  // ---- goals: index 0 = left (starts up), 1 = right (starts down) ----
  for (genvar g = 0; g < 2; g++) begin : g_goal
    goal_mover #(
      .Y_W     (Y_W),
      .Y_MAX   (SCREEN_H - GOAL_H),
      .Y0      (GOAL_Y0),
      .INIT_UP (g == 0)
    ) u_mover (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .step_en (tick && state_q == ST_PLAY),
      .step    (step),
      .pos     (goal_y[g])
    );
  end

  assign goal_y_l = goal_y[0];
  assign goal_y_r = goal_y[1];

endmodule

// File: tb/tb_hockey_game_ctrl.sv
// tb_hockey_game_ctrl: scoreboard bench for hockey_game_ctrl.
// The stimulus process drives one cycle of inputs, advances a behavioural
// match model and queues the expected outputs; a monitor on the falling
// edge pops and compares whenever an expected entry is due.
module tb_hockey_game_ctrl;

  localparam int WIN_SCORE = 7, SCORE_W = 3, NUM_MODES = 7, Y_W = 9;
  localparam int SCREEN_H = 480, GOAL_H = 160, GOAL_Y0 = 160;
  localparam int STEP_SLOW = 2, STEP_FAST = 5, SERVE_TICKS = 60;
  localparam int YMAX = SCREEN_H - GOAL_H;

  logic clk = 0, reset = 1, tick = 0, key_stb = 0, key_rel = 0, goal_l = 0, goal_r = 0;
  logic [7:0] key_code = 0;
  logic [2:0] state, mode;
  logic [SCORE_W-1:0] score_l, score_r;
  logic [Y_W-1:0] goal_y_l, goal_y_r;
  logic play_en, serve, win_l, win_r;

  always #5 clk = ~clk;

  hockey_game_ctrl #(
    .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W), .NUM_MODES(NUM_MODES), .Y_W(Y_W),
    .SCREEN_H(SCREEN_H), .GOAL_H(GOAL_H), .GOAL_Y0(GOAL_Y0),
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .SERVE_TICKS(SERVE_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .key_stb(key_stb), .key_code(key_code),
    .key_rel(key_rel), .goal_l(goal_l), .goal_r(goal_r), .state(state), .mode(mode),
    .score_l(score_l), .score_r(score_r), .goal_y_l(goal_y_l), .goal_y_r(goal_y_r),
    .play_en(play_en), .serve(serve), .win_l(win_l), .win_r(win_r)
  );

  typedef struct {
    int cyc;
    int st, md, sl, sr, yl, yr, pe, sv, wl, wr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int cyc_cnt = 0, n_chk = 0, n_fail = 0;

  // behavioural match model
  int m_st, m_mode, m_sl, m_sr, m_yl, m_yr, m_dl, m_dr, m_cnt, m_wl, m_wr, m_pe, m_sv;
  int mode_keys [8] = '{'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E};

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int key_idx(input int code);
    for (int i = 0; i < 8; i++) if (mode_keys[i] == code) return i;
    return -1;
  endfunction

  function automatic int step_of(input int m);
    return (m >= 6) ? STEP_FAST : (m >= 4) ? STEP_SLOW : 0;
  endfunction

  task automatic move(inout int y, inout int d, input int s);
    int ny;
    ny = y + d * s;
    if (ny < 0)         begin y = 0;    d = 1;  end
    else if (ny > YMAX) begin y = YMAX; d = -1; end
    else                y = ny;
  endtask

  task automatic model(input bit r, t, s, input int code, input bit rel, gl, gr);
    bit mk;
    int ns, k;
    if (r) begin
      m_st = 0; m_mode = 0; m_sl = 0; m_sr = 0; m_yl = GOAL_Y0; m_yr = GOAL_Y0;
      m_dl = -1; m_dr = 1; m_cnt = 0; m_wl = 0; m_wr = 0; m_pe = 0; m_sv = 0;
      return;
    end
    mk = s && !rel;
    ns = m_st;
    m_sv = 0;
    if (m_st == 1 && t) begin
      move(m_yl, m_dl, step_of(m_mode));
      move(m_yr, m_dr, step_of(m_mode));
    end
    case (m_st)
      0: if (mk) begin
           k = key_idx(code);
           if (k >= 0 && k < NUM_MODES) m_mode = k;
           if (code == 'h29 || code == 'h5A) begin
             ns = 1; m_sl = 0; m_sr = 0; m_wl = 0; m_wr = 0; m_sv = 1;
             m_yl = GOAL_Y0; m_yr = GOAL_Y0; m_dl = -1; m_dr = 1;
           end
         end
      1: if (mk) begin
           if (code == 'h66)      ns = 0;
           else if (code == 'h76) ns = 3;
`ifdef HOCKEY_PAUSE_EN
           else if (code == 'h4D) ns = 4;
`endif
         end else if (gl) begin
           if (m_sr < WIN_SCORE) m_sr++;
           if (m_sr == WIN_SCORE) begin ns = 3; m_wr = 1; end
           else begin ns = 2; m_cnt = 0; end
         end else if (gr) begin
           if (m_sl < WIN_SCORE) m_sl++;
           if (m_sl == WIN_SCORE) begin ns = 3; m_wl = 1; end
           else begin ns = 2; m_cnt = 0; end
         end
      2: if (mk && code == 'h66) ns = 0;
         else if (t) begin
           m_cnt++;
           if (m_cnt == SERVE_TICKS) begin ns = 1; m_sv = 1; end
         end
      3: if (mk && code == 'h66) ns = 0;
      4: if (mk && code == 'h66) ns = 0;
         else if (mk && code == 'h4D) ns = 1;
      default: ;
    endcase
    m_st = ns;
    m_pe = (ns == 1);
  endtask

  task automatic cyc(input bit r, t, s, input int code, input bit rel, gl, gr);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; tick = t; key_stb = s; key_code = 8'(code); key_rel = rel;
    goal_l = gl; goal_r = gr;
    model(r, t, s, code, rel, gl, gr);
    x = '{cyc_cnt + 1, m_st, m_mode, m_sl, m_sr, m_yl, m_yr, m_pe, m_sv, m_wl, m_wr};
    q.push_back(x);
  endtask

  task automatic idle(input int n, input bit t);
    for (int i = 0; i < n; i++) cyc(0, t, 0, 0, 0, 0, 0);
  endtask

  task automatic key(input int code);
    cyc(0, 0, 1, code, 0, 0, 0);
  endtask

  // monitor
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc_cnt) begin
      e = q.pop_front();
      n_chk++;
      if (state !== 3'(e.st) || mode !== 3'(e.md) || score_l !== SCORE_W'(e.sl) ||
          score_r !== SCORE_W'(e.sr) || goal_y_l !== Y_W'(e.yl) || goal_y_r !== Y_W'(e.yr) ||
          play_en !== 1'(e.pe) || serve !== 1'(e.sv) || win_l !== 1'(e.wl) || win_r !== 1'(e.wr)) begin
        n_fail++;
        $display("FAIL outputs cyc %0d: got st=%0d md=%0d sc=%0d/%0d y=%0d/%0d pe=%0d sv=%0d w=%0d/%0d want st=%0d md=%0d sc=%0d/%0d y=%0d/%0d pe=%0d sv=%0d w=%0d/%0d",
                 cyc_cnt, state, mode, score_l, score_r, goal_y_l, goal_y_r, play_en, serve, win_l, win_r,
                 e.st, e.md, e.sl, e.sr, e.yl, e.yr, e.pe, e.sv, e.wl, e.wr);
      end
    end
  end

  initial begin
    bit r, t, s, rel, gl, gr;
    int code, pick;

    // reset state
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2, 0);

    // mode 6 then start
    key('h3D);
    idle(1, 0);
    key('h5A);
    idle(2, 0);

    // moving goals: bounce off both bounds
    idle(40, 1);

    // left player scores to the win, serve delay after each goal
    for (int g = 0; g < 7; g++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      idle(SERVE_TICKS, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(2, 1);

    // back to menu; out-of-range mode key and a break code are ignored
    key('h66);
    key('h3E);
    cyc(0, 0, 1, 'h16, 1, 0, 0);
    idle(1, 0);
    key('h29);
    idle(2, 1);

    // simultaneous goals: left goal wins, right dropped
    cyc(0, 0, 0, 0, 0, 1, 1);
    idle(SERVE_TICKS, 1);
    idle(3, 1);

    // key and goal together: goal dropped
    cyc(0, 1, 1, 'h1C, 0, 0, 1);
    idle(2, 1);

`ifdef HOCKEY_PAUSE_EN
    key('h4D);
    idle(10, 1);
    key('h4D);
    idle(3, 1);
    key('h4D);
    key('h66);
`endif

    // quit mid-match
    key('h29);
    idle(5, 1);
    key('h76);
    idle(2, 1);
    key('h66);

    // randomized play
    for (int i = 0; i < 6000; i++) begin
      r    = ($urandom_range(0, 1499) == 0);
      t    = $urandom_range(0, 1);
      s    = ($urandom_range(0, 24) == 0);
      rel  = ($urandom_range(0, 3) == 0);
      gl   = ($urandom_range(0, 11) == 0);
      gr   = ($urandom_range(0, 11) == 0);
      pick = $urandom_range(0, 15);
      if (pick < 6)        code = mode_keys[$urandom_range(0, 7)];
      else if (pick < 8)   code = $urandom_range(0, 1) ? 'h29 : 'h5A;
      else if (pick == 8)  code = 'h66;
      else if (pick == 9)  code = 'h76;
      else if (pick < 12)  code = 'h4D;
      else                 code = $urandom_range(0, 255);
      cyc(r, t, s, code, rel, gl, gr);
    end

    idle(2, 0);
    @(posedge clk);
    #6;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
